// File: rtl/dm_uncached_bridge.sv
// Uncached data-side bus master: turns one level load/store request from the memory
// stage into a single SRAM-like bus transaction and returns data plus a one-cycle data_ok.
module dm_uncached_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              resetn,
  input  logic              read,
  input  logic              write,
  input  logic              uncached,
  input  logic              exp_flush,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [3:0]        req_wstrb,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              data_sram_data_ok,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;
  logic   killed;
  logic   kill_now;
  logic   issue;

  // A flush arriving in the completing cycle kills the response just like an earlier one.
  assign kill_now = killed | exp_flush;
  assign issue    = (read | write) & uncached & ~exp_flush;

  always_ff @(posedge Clk) begin
    if (!resetn) begin
      state             <= S_IDLE;
      killed            <= 1'b0;
      data_req          <= 1'b0;
      data_wr           <= 1'b0;
      data_size         <= '0;
      data_addr         <= '0;
      data_wstrb        <= '0;
      data_wdata        <= '0;
      data_sram_rdata   <= '0;
      data_sram_data_ok <= 1'b0;
      busy              <= 1'b0;
    end else begin
      data_sram_data_ok <= 1'b0;
      case (state)
        S_IDLE: begin
          killed <= 1'b0;
          if (issue) begin
            state      <= S_REQ;
            data_req   <= 1'b1;
            busy       <= 1'b1;
            data_wr    <= write & ~read;
            data_addr  <= req_addr;
            data_size  <= req_size;
            data_wstrb <= req_wstrb;
            data_wdata <= req_wdata;
          end
        end

        S_REQ: begin
          if (data_addr_ok) begin
            data_req <= 1'b0;
            if (data_data_ok) begin
              busy <= 1'b0;
              if (kill_now) begin
                state  <= S_IDLE;
                killed <= 1'b0;
              end else begin
                state             <= S_DONE;
                data_sram_data_ok <= 1'b1;
                if (!data_wr) data_sram_rdata <= data_rdata;
              end
            end else begin
              state  <= S_WAIT;
              killed <= kill_now;
            end
          end else begin
            killed <= kill_now;
          end
        end

        S_WAIT: begin
          if (data_data_ok) begin
            busy <= 1'b0;
            if (kill_now) begin
              state  <= S_IDLE;
              killed <= 1'b0;
            end else begin
              state             <= S_DONE;
              data_sram_data_ok <= 1'b1;
              if (!data_wr) data_sram_rdata <= data_rdata;
            end
          end else begin
            killed <= kill_now;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state    <= S_IDLE;
          killed   <= 1'b0;
          data_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_uncached_bridge.sv
// Directed bench for dm_uncached_bridge: a per-cycle vector table plus hand-written
// sequences for flush, reset-in-flight and killed-transaction corner cases.
module tb_dm_uncached_bridge;

  logic        Clk = 1'b0;
  logic        resetn;
  logic        read, write, uncached, exp_flush;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] data_sram_rdata;
  logic        data_sram_data_ok;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  dm_uncached_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk(Clk),
    .resetn(resetn),
    .read(read),
    .write(write),
    .uncached(uncached),
    .exp_flush(exp_flush),
    .req_addr(req_addr),
    .req_size(req_size),
    .req_wstrb(req_wstrb),
    .req_wdata(req_wdata),
    .data_req(data_req),
    .data_wr(data_wr),
    .data_size(data_size),
    .data_addr(data_addr),
    .data_wstrb(data_wstrb),
    .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .data_sram_rdata(data_sram_rdata),
    .data_sram_data_ok(data_sram_data_ok),
    .busy(busy)
  );

  // One vector: inputs driven for a cycle, then outputs expected just after the next edge.
  typedef struct {
    logic        rd, wr, unc, fl;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        aok, dok;
    logic [31:0] rdata;
    logic        e_req, e_busy, e_ok;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rd, logic wr, logic unc, logic fl, logic [31:0] addr,
                              logic [1:0] size, logic [3:0] strb, logic [31:0] wdata,
                              logic aok, logic dok, logic [31:0] rdata,
                              logic e_req, logic e_busy, logic e_ok, logic [31:0] e_rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.unc = unc; v.fl = fl;
    v.addr = addr; v.size = size; v.strb = strb; v.wdata = wdata;
    v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.e_req = e_req; v.e_busy = e_busy; v.e_ok = e_ok; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    read = 0; write = 0; uncached = 0; exp_flush = 0;
    req_addr = '0; req_size = '0; req_wstrb = '0; req_wdata = '0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    read = v.rd; write = v.wr; uncached = v.unc; exp_flush = v.fl;
    req_addr = v.addr; req_size = v.size; req_wstrb = v.strb; req_wdata = v.wdata;
    data_addr_ok = v.aok; data_data_ok = v.dok; data_rdata = v.rdata;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check_val($sformatf("v%0d data_req", idx), 32'(data_req), 32'(v.e_req));
    check_val($sformatf("v%0d busy", idx), 32'(busy), 32'(v.e_busy));
    check_val($sformatf("v%0d sram_data_ok", idx), 32'(data_sram_data_ok), 32'(v.e_ok));
    check_val($sformatf("v%0d sram_rdata", idx), data_sram_rdata, v.e_rdata);
    if (v.e_req) begin
      check_val($sformatf("v%0d data_wr", idx), 32'(data_wr), 32'(v.wr & ~v.rd));
      check_val($sformatf("v%0d data_addr", idx), data_addr, v.addr);
      check_val($sformatf("v%0d data_size", idx), 32'(data_size), 32'(v.size));
      check_val($sformatf("v%0d data_wstrb", idx), 32'(data_wstrb), 32'(v.strb));
      check_val($sformatf("v%0d data_wdata", idx), data_wdata, v.wdata);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, " data_req"}, 32'(data_req), 0);
    check_val({tag, " data_wr"}, 32'(data_wr), 0);
    check_val({tag, " data_size"}, 32'(data_size), 0);
    check_val({tag, " data_addr"}, data_addr, 0);
    check_val({tag, " data_wstrb"}, 32'(data_wstrb), 0);
    check_val({tag, " data_wdata"}, data_wdata, 0);
    check_val({tag, " sram_rdata"}, data_sram_rdata, 0);
    check_val({tag, " sram_data_ok"}, 32'(data_sram_data_ok), 0);
    check_val({tag, " busy"}, 32'(busy), 0);
  endtask

  // Zero-wait load: request seen, addr_ok in the first REQ cycle, data_ok the next.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] rdata);
    idle_inputs();
    read = 1; uncached = 1; req_addr = addr; req_size = 2'd2;
    step();
    check_val({tag, " req"}, 32'(data_req), 1);
    check_val({tag, " addr"}, data_addr, addr);
    data_addr_ok = 1;
    step();
    check_val({tag, " wait busy"}, 32'(busy), 1);
    data_addr_ok = 0; data_data_ok = 1; data_rdata = rdata;
    step();
    check_val({tag, " pulse"}, 32'(data_sram_data_ok), 1);
    check_val({tag, " rdata"}, data_sram_rdata, rdata);
    idle_inputs();
    step();
    check_val({tag, " pulse end"}, 32'(data_sram_data_ok), 0);
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    step();
    step();
    check_all_zero("reset");
    resetn = 1;

    // Uncached lw, immediate handshakes.
    vecs.push_back(mk(1,0,1,0, 32'hBFC0_0010, 2, 4'h0, 0, 0,0, 0,            1,1,0, 0));
    vecs.push_back(mk(1,0,1,0, 32'hBFC0_0010, 2, 4'h0, 0, 1,0, 0,            0,1,0, 0));
    vecs.push_back(mk(1,0,1,0, 32'hBFC0_0010, 2, 4'h0, 0, 0,1, 32'h1234_5678, 0,0,1, 32'h1234_5678));
    vecs.push_back(mk(0,0,0,0, 0,             0, 4'h0, 0, 0,0, 0,            0,0,0, 32'h1234_5678));
    // Uncached sb, addr_ok only in the fourth request cycle.
    vecs.push_back(mk(0,1,1,0, 32'hBFAF_F003, 0, 4'b1000, 32'hAB00_0000, 0,0, 0, 1,1,0, 32'h1234_5678));
    vecs.push_back(mk(0,1,1,0, 32'hBFAF_F003, 0, 4'b1000, 32'hAB00_0000, 0,0, 0, 1,1,0, 32'h1234_5678));
    vecs.push_back(mk(0,1,1,0, 32'hBFAF_F003, 0, 4'b1000, 32'hAB00_0000, 0,0, 0, 1,1,0, 32'h1234_5678));
    vecs.push_back(mk(0,1,1,0, 32'hBFAF_F003, 0, 4'b1000, 32'hAB00_0000, 1,0, 0, 0,1,0, 32'h1234_5678));
    vecs.push_back(mk(0,1,1,0, 32'hBFAF_F003, 0, 4'b1000, 32'hAB00_0000, 0,1, 32'hFFFF_FFFF, 0,0,1, 32'h1234_5678));
    vecs.push_back(mk(0,0,0,0, 0, 0, 4'h0, 0, 0,0, 0, 0,0,0, 32'h1234_5678));
    // Cached reads are ignored.
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1,0,0,0, 32'h8000_0000 + 32'(i*4), 2, 4'h0, 0, 0,0, 0, 0,0,0, 32'h1234_5678));
    // A flush in IDLE blocks the issue.
    vecs.push_back(mk(1,0,1,1, 32'hBFC0_0020, 2, 4'h0, 0, 0,0, 0, 0,0,0, 32'h1234_5678));
    // Back-to-back loads with read held through DONE; first one completes addr_ok+data_ok together.
    vecs.push_back(mk(1,0,1,0, 32'h1FC0_0100, 2, 4'h0, 0, 0,0, 0,            1,1,0, 32'h1234_5678));
    vecs.push_back(mk(1,0,1,0, 32'h1FC0_0100, 2, 4'h0, 0, 1,1, 32'h1111_1111, 0,0,1, 32'h1111_1111));
    vecs.push_back(mk(1,0,1,0, 32'h1FC0_0104, 2, 4'h0, 0, 0,0, 0,            0,0,0, 32'h1111_1111));
    vecs.push_back(mk(1,0,1,0, 32'h1FC0_0104, 2, 4'h0, 0, 0,0, 0,            1,1,0, 32'h1111_1111));
    vecs.push_back(mk(1,0,1,0, 32'h1FC0_0104, 2, 4'h0, 0, 1,0, 0,            0,1,0, 32'h1111_1111));
    vecs.push_back(mk(1,0,1,0, 32'h1FC0_0104, 2, 4'h0, 0, 0,1, 32'h2222_2222, 0,0,1, 32'h2222_2222));
    vecs.push_back(mk(0,0,0,0, 0, 0, 4'h0, 0, 0,0, 0, 0,0,0, 32'h2222_2222));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput(vecs[i], i);
    end

    // Flush while waiting for data: bus completes, response swallowed.
    idle_inputs();
    read = 1; uncached = 1; req_addr = 32'hBFC0_0040; req_size = 2'd2;
    step();
    data_addr_ok = 1;
    step();
    data_addr_ok = 0; exp_flush = 1; read = 0;
    step();
    check_val("flushwait busy1", 32'(busy), 1);
    exp_flush = 0;
    step();
    check_val("flushwait busy2", 32'(busy), 1);
    data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
    step();
    check_val("flushwait busy3", 32'(busy), 0);
    check_val("flushwait pulse", 32'(data_sram_data_ok), 0);
    check_val("flushwait rdata", data_sram_rdata, 32'h2222_2222);
    idle_inputs();
    step();
    check_val("flushwait pulse2", 32'(data_sram_data_ok), 0);

    // Flush during REQ: request is held until addr_ok with its latched fields.
    read = 1; uncached = 1; req_addr = 32'hA000_0020; req_size = 2'd2;
    step();
    read = 0; exp_flush = 1; req_addr = 32'h0000_0000;
    step();
    check_val("flushreq req", 32'(data_req), 1);
    check_val("flushreq addr", data_addr, 32'hA000_0020);
    exp_flush = 0;
    step();
    check_val("flushreq req2", 32'(data_req), 1);
    data_addr_ok = 1;
    step();
    check_val("flushreq req3", 32'(data_req), 0);
    check_val("flushreq busy", 32'(busy), 1);
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0BAD_F00D;
    step();
    check_val("flushreq pulse", 32'(data_sram_data_ok), 0);
    check_val("flushreq rdata", data_sram_rdata, 32'h2222_2222);
    idle_inputs();
    step();
    check_val("flushreq pulse2", 32'(data_sram_data_ok), 0);

    do_load("after kill", 32'hBFC0_0080, 32'h3333_3333);

    // Reset while waiting for data.
    read = 1; uncached = 1; req_addr = 32'hBFC0_00C0; req_size = 2'd2;
    step();
    data_addr_ok = 1;
    step();
    idle_inputs();
    resetn = 0;
    step();
    check_all_zero("midreset");
    resetn = 1; data_data_ok = 1; data_rdata = 32'hCAFE_CAFE;
    step();
    check_all_zero("stale data_ok");
    idle_inputs();
    step();
    do_load("after reset", 32'h1000_0000, 32'h5A5A_5A5A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
